fir_ctrl_mc: RTL

FIR_CTRL_MC -- requirements
Module: fir_ctrl_mc

---
 rtl/fir_ctrl_mc_if.sv | 30 +++
 rtl/fir_ctrl_mc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl_mc_if.sv
// Bus bundle of the multichannel FIR controller: input frame strobe and data,
// external coefficient ROM port, filtered output frame and status flags.
// The slave modport is the controller side, the master modport its environment.
interface fir_ctrl_mc_if #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 101,
    parameter int CHANNELS = 2
);
    localparam int ADDR_W = $clog2(TAPS);

    logic                       sample_end;
    logic [CHANNELS*DATA_W-1:0] in_data;
    logic [ADDR_W-1:0]          coef_addr;
    logic signed [COEF_W-1:0]   coef_data;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic                       out_valid;
    logic                       busy;
    logic                       overrun;

    modport master (
        output sample_end, in_data, coef_data,
        input  coef_addr, out_data, out_valid, busy, overrun
    );

    modport slave (
        input  sample_end, in_data, coef_data,
        output coef_addr, out_data, out_valid, busy, overrun
    );
endinterface

// File: rtl/fir_ctrl_mc.sv
// fir_ctrl_mc: time-multiplexed FIR filter for CHANNELS channels sharing one
// coefficient set read from an external synchronous ROM (1-cycle latency).
// A rising edge on sample_end captures a frame, writes it into per-channel
// ring buffers, then runs one MAC pass per channel and publishes all results
// together with a one-cycle out_valid pulse.
// Optional feature: define FIR_CTRL_SAT_EN to clamp results to DATA_W bits;
// without it the shifted result wraps to its low DATA_W bits.
module fir_ctrl_mc #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 101,
    parameter int CHANNELS = 2
) (
    input  logic         clk,
    input  logic         reset,
    fir_ctrl_mc_if.slave bus
);
    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int CNT_W  = $clog2(TAPS + 2);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FILL_W = $clog2(TAPS + 1);

    localparam logic [CNT_W-1:0]  CNT_TAPS = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TAPS + 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(TAPS - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAPS);

    typedef enum logic [1:0] {IDLE, WRITE, MAC, STORE} state_t;

    // Floor division by 2^(COEF_W-1): drops the fractional bits of the Q1 product sum
    function automatic logic signed [ACC_W-1:0] shift_floor(input logic signed [ACC_W-1:0] sum);
        return sum >>> (COEF_W - 1);
    endfunction

`ifdef FIR_CTRL_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Clamp the shifted sum into the signed DATA_W range
    function automatic logic signed [DATA_W-1:0] fit_width(input logic signed [ACC_W-1:0] val);
        if (val > SAT_HI) return {1'b0, {(DATA_W-1){1'b1}}};
        if (val < SAT_LO) return {1'b1, {(DATA_W-1){1'b0}}};
        return DATA_W'(val);
    endfunction
`else
    // Keep the low DATA_W bits of the shifted sum (two's complement wrap)
    function automatic logic signed [DATA_W-1:0] fit_width(input logic signed [ACC_W-1:0] val);
        return DATA_W'(val);
    endfunction
`endif

    state_t                     state, state_nxt;
    logic                       sample_end_q;
    logic                       rise;
    logic [ADDR_W-1:0]          wr_ptr;
    logic [FILL_W-1:0]          fill;
    logic [CNT_W-1:0]           cnt;
    logic [CH_W-1:0]            ch;
    logic                       overrun;
    logic [CHANNELS*DATA_W-1:0] frame_q;
    logic signed [DATA_W-1:0]   ring [CHANNELS][TAPS];
    logic signed [DATA_W-1:0]   result [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic                       out_valid;

    logic                       issue;
    logic [CNT_W-1:0]           tap;
    logic [31:0]                rd_sum;
    logic [ADDR_W-1:0]          rd_idx;
    logic                       tap_live;
    logic                       chan_done;
    logic signed [ACC_W-1:0]    acc_sum;

    logic signed [DATA_W-1:0]   x_p0;
    logic                       vld_p0;
    logic signed [PROD_W-1:0]   prod_p1;
    logic                       vld_p1;
    logic signed [ACC_W-1:0]    acc;

    assign rise          = bus.sample_end & ~sample_end_q;
    assign bus.busy      = (state != IDLE);
    assign bus.coef_addr = tap[ADDR_W-1:0];
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.overrun   = overrun;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: one frame flows IDLE -> WRITE -> MAC (all channels) -> STORE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = WRITE;
            WRITE:   state_nxt = MAC;
            MAC:     if ((cnt == CNT_LAST) && (ch == CH_LAST)) state_nxt = STORE;
            STORE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue decode: tap index, ring read position (newest sample first) and warm-up mask
    always_comb begin
        issue     = (state == MAC) && (cnt < CNT_TAPS);
        tap       = issue ? cnt : '0;
        rd_sum    = 32'(wr_ptr) + 32'(TAPS - 1) - 32'(tap);
        if (rd_sum >= 32'(TAPS)) rd_sum = rd_sum - 32'(TAPS);
        rd_idx    = ADDR_W'(rd_sum);
        tap_live  = 32'(tap) < 32'(fill);
        chan_done = (state == MAC) && (cnt == CNT_LAST);
        acc_sum   = acc + ACC_W'(prod_p1);
    end

    // Edge detector and sticky drop flag; a rise outside IDLE is a dropped frame
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_end_q <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_end_q <= bus.sample_end;
            if (rise && (state != IDLE)) overrun <= 1'b1;
        end
    end

    // Capture the frame present in the accepted rise cycle
    always_ff @(posedge clk) begin
        if (rise && (state == IDLE)) frame_q <= bus.in_data;
    end

    // Ring write of all channels at the shared write pointer
    always_ff @(posedge clk) begin
        if (state == WRITE) begin
            for (int c = 0; c < CHANNELS; c++) ring[c][wr_ptr] <= frame_q[c*DATA_W +: DATA_W];
        end
    end

    // Write pointer and saturating fill count of valid ring entries
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (state == WRITE) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (fill != FILL_MAX) fill <= fill + 1'b1;
        end
    end

    // Tap/channel sequencer: TAPS issue cycles plus two pipeline drain cycles per channel
    always_ff @(posedge clk) begin
        if (reset || (state != MAC)) begin
            cnt <= '0;
            ch  <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Valid flags travelling with the read and multiply stages
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p0: ring read, aligned with the ROM word arriving next cycle
    always_ff @(posedge clk) begin
        x_p0 <= tap_live ? ring[ch][rd_idx] : '0;
    end

    // Stage p1: registered product
    always_ff @(posedge clk) begin
        prod_p1 <= PROD_W'(x_p0) * PROD_W'(bus.coef_data);
    end

    // Accumulate stage: restarts at each channel boundary
    always_ff @(posedge clk) begin
        if (reset)         acc <= '0;
        else if (chan_done) acc <= '0;
        else if (vld_p1)   acc <= acc_sum;
    end

    // Park each finished channel result until the whole frame is done
    always_ff @(posedge clk) begin
        if (chan_done) result[ch] <= fit_width(shift_floor(acc_sum));
    end

    // Publish all channels at once with a single-cycle valid pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= (state == STORE);
            if (state == STORE) begin
                for (int c = 0; c < CHANNELS; c++) out_data[c*DATA_W +: DATA_W] <= result[c];
            end
        end
    end
endmodule
